// File: rtl/chaos_seq_pkg.sv
// chaos_seq_pkg: state codes, sample packing offsets and widths shared by the chaos step sequencer
package chaos_seq_pkg;
  localparam int DATA_W = 32;
  localparam int STEP_W = 16;
  localparam int X_OFF = 0;
  localparam int Y_OFF = 8;
  localparam int Z_OFF = 16;
  localparam int W_OFF = 24;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_RST  = 3'd1;
  localparam state_t S_STEP = 3'd2;
  localparam state_t S_WAIT = 3'd3;
  localparam state_t S_PUSH = 3'd4;
  localparam state_t S_FIN  = 3'd5;
endpackage

// File: rtl/chaos_sample_fifo.sv
// chaos_sample_fifo: first-word fall-through sample FIFO; head reads as zero while empty
module chaos_sample_fifo
  import chaos_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd;
  logic w_push, w_pop;
  assign empty = r_wr == r_rd;
  assign full = (r_wr ^ r_rd) == {1'b1, {AW{1'b0}}};
  assign w_push = push & ~full;
  assign w_pop = pop & ~empty;
  assign dout = empty ? '0 : r_mem[r_rd[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr[AW-1:0]] <= din;
endmodule

// File: rtl/chaos_step_sequencer.sv
// chaos_step_sequencer: runs reset then N step/done handshakes on the chaos core, buffering samples
// Define CHAOS_TIMEOUT_EN to enable the sticky watchdog on chaos_done_i.
module chaos_step_sequencer
  import chaos_seq_pkg::*;
#(
  parameter int RST_CYCLES  = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              start,
  input  logic [STEP_W-1:0] num_steps,
  input  logic [31:0]       shift_cfg,
  input  logic              abort,
  output logic              chaos_reset_o,
  output logic [31:0]       chaos_shift_o,
  output logic              chaos_step_o,
  input  logic              chaos_done_i,
  input  logic [7:0]        chaos_x_i,
  input  logic [7:0]        chaos_y_i,
  input  logic [7:0]        chaos_z_i,
  input  logic [7:0]        chaos_w_i,
  output logic [DATA_W-1:0] smp_data,
  output logic              smp_valid,
  input  logic              smp_ready,
  output logic              busy,
  output logic              run_done,
  output logic [STEP_W-1:0] steps_done,
  output logic              timeout_err
);
  // One counter serves both the reset hold and the done watchdog
  localparam int CW = $clog2((RST_CYCLES > TIMEOUT_CYC ? RST_CYCLES : TIMEOUT_CYC) + 1);
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [STEP_W-1:0] r_num, r_steps;
  logic [DATA_W-1:0] r_sample;
  logic [31:0] r_shift;
  logic w_full, w_empty, w_push, w_rst_done, w_last, w_to_hit;
  assign w_rst_done = r_cnt == CW'(RST_CYCLES - 1);
  assign w_last = r_steps + 1'b1 == r_num;
  assign w_push = r_state == S_PUSH & ~w_full & ~abort;
`ifdef CHAOS_TIMEOUT_EN
  logic r_to;
  assign w_to_hit = r_cnt == CW'(TIMEOUT_CYC - 1);
  assign timeout_err = r_to;
  always_ff @(posedge clk_clk or posedge reset_reset)
    if (reset_reset) r_to <= 1'b0;
    else if (r_state == S_IDLE && start) r_to <= 1'b0;
    else if (r_state == S_WAIT && !chaos_done_i && w_to_hit && !abort) r_to <= 1'b1;
`else
  assign w_to_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    if (abort && r_state != S_IDLE) w_next = S_IDLE;
    else
      case (r_state)
        S_IDLE: w_next = start ? S_RST : S_IDLE;
        S_RST:  if (w_rst_done) w_next = r_num == '0 ? S_FIN : S_STEP;
        S_STEP: w_next = S_WAIT;
        S_WAIT: w_next = chaos_done_i ? S_PUSH : w_to_hit ? S_IDLE : S_WAIT;
        S_PUSH: if (!w_full) w_next = w_last ? S_FIN : S_STEP;
        default: w_next = S_IDLE;
      endcase
  end
  always_ff @(posedge clk_clk or posedge reset_reset)
    if (reset_reset) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_num <= '0;
      r_steps <= '0;
      r_sample <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= (w_next == r_state && (r_state == S_RST || r_state == S_WAIT)) ? r_cnt + 1'b1 : '0;
      if (r_state == S_IDLE && start) begin
        r_num <= num_steps;
        r_shift <= shift_cfg;
        r_steps <= '0;
      end
      if (r_state == S_WAIT && chaos_done_i && !abort) begin
        r_sample[X_OFF +: 8] <= chaos_x_i;
        r_sample[Y_OFF +: 8] <= chaos_y_i;
        r_sample[Z_OFF +: 8] <= chaos_z_i;
        r_sample[W_OFF +: 8] <= chaos_w_i;
      end
      if (w_push) r_steps <= r_steps + 1'b1;
    end
  chaos_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk_clk),
    .rst  (reset_reset),
    .push (w_push),
    .pop  (smp_ready),
    .din  (r_sample),
    .dout (smp_data),
    .full (w_full),
    .empty(w_empty)
  );
  // Abort silences the core-facing strobes in the very cycle it is seen
  assign chaos_reset_o = r_state == S_RST & ~abort;
  assign chaos_step_o = r_state == S_STEP & ~abort;
  assign run_done = r_state == S_FIN & ~abort;
  assign busy = r_state != S_IDLE;
  assign smp_valid = ~w_empty;
  assign steps_done = r_steps;
  assign chaos_shift_o = r_shift;
endmodule

// File: tb/tb_chaos_step_sequencer.sv
// tb_chaos_step_sequencer: directed runs against a chaos core model with a queue-based sample scoreboard
module tb_chaos_step_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [15:0] num_steps = '0;
  logic [31:0] shift_cfg = '0;
  logic abort = 1'b0;
  logic chaos_reset_o, chaos_step_o, chaos_done_i;
  logic [31:0] chaos_shift_o;
  logic [7:0] cx, cy, cz, cw;
  logic [31:0] smp_data;
  logic smp_valid;
  logic smp_ready = 1'b1;
  logic busy, run_done, timeout_err;
  logic [15:0] steps_done;
  int n_chk = 0;
  int n_fail = 0;
  int step_cnt = 0;
  int rst_cnt = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];
  logic core_en = 1'b1;
  int core_cnt;
  logic [7:0] core_i;
  always #5 clk = ~clk;
  chaos_step_sequencer #(.RST_CYCLES(4), .FIFO_DEPTH(8), .TIMEOUT_CYC(16)) dut (
    .clk_clk(clk), .reset_reset(rst), .start(start), .num_steps(num_steps),
    .shift_cfg(shift_cfg), .abort(abort), .chaos_reset_o(chaos_reset_o),
    .chaos_shift_o(chaos_shift_o), .chaos_step_o(chaos_step_o), .chaos_done_i(chaos_done_i),
    .chaos_x_i(cx), .chaos_y_i(cy), .chaos_z_i(cz), .chaos_w_i(cw),
    .smp_data(smp_data), .smp_valid(smp_valid), .smp_ready(smp_ready), .busy(busy),
    .run_done(run_done), .steps_done(steps_done), .timeout_err(timeout_err)
  );
  // Core model: done rises two cycles after each step pulse, state = i, i+1, i+2, i+3
  always @(posedge clk or posedge rst)
    if (rst || chaos_reset_o) begin
      chaos_done_i <= 1'b0;
      core_cnt <= 0;
      core_i <= '0;
      {cx, cy, cz, cw} <= '0;
    end else if (chaos_step_o) begin
      chaos_done_i <= 1'b0;
      core_cnt <= 1;
    end else if (core_cnt == 1) begin
      core_cnt <= 0;
      if (core_en) begin
        chaos_done_i <= 1'b1;
        cx <= core_i;
        cy <= core_i + 8'd1;
        cz <= core_i + 8'd2;
        cw <= core_i + 8'd3;
        core_i <= core_i + 8'd1;
      end
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] word(input int i);
    return {8'(i + 3), 8'(i + 2), 8'(i + 1), 8'(i)};
  endfunction
  always @(negedge clk) begin
    if (chaos_step_o) step_cnt++;
    if (chaos_reset_o) rst_cnt++;
    if (run_done) done_cnt++;
    if (smp_valid && smp_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected_pop", smp_data, 32'hxxxx_xxxx);
      else chk("sb_data", smp_data, exp_q.pop_front());
    end
  end
  task automatic clr();
    step_cnt = 0;
    rst_cnt = 0;
    done_cnt = 0;
  endtask
  task automatic start_run(input logic [15:0] n, input logic [31:0] s);
    @(posedge clk); #1;
    num_steps = n;
    shift_cfg = s;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("idle_bound", 32'(k < budget), 32'd1);
  endtask
  task automatic wait_step(input logic [15:0] n);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(chaos_step_o && steps_done == n) && k < 300);
    chk("step_bound", 32'(k < 300), 32'd1);
  endtask
  initial begin
    int first;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", smp_valid, 0);
    chk("rst_data", smp_data, 0);
    chk("rst_steps", steps_done, 0);
    chk("rst_core_rst", chaos_reset_o, 0);
    chk("rst_shift", chaos_shift_o, 0);
    chk("rst_tmo", timeout_err, 0);
    rst = 1'b0;
    // Basic three-step run
    clr();
    start_run(16'd3, 32'hA5A5_0001);
    for (int i = 0; i < 3; i++) exp_q.push_back(word(i));
    chk("t1_shift", chaos_shift_o, 32'hA5A5_0001);
    chk("t1_core_rst", chaos_reset_o, 1);
    wait_idle(200);
    repeat (3) @(negedge clk);
    chk("t1_rst_cycles", rst_cnt, 4);
    chk("t1_steps", step_cnt, 3);
    chk("t1_run_done", done_cnt, 1);
    chk("t1_steps_done", steps_done, 3);
    chk("t1_sb_empty", exp_q.size(), 0);
    // Reset-only run
    clr();
    first = 0;
    start_run(16'd0, 32'h1234_5678);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (run_done && first == 0) first = k;
    end
    chk("t2_done_cycle", first, 5);
    chk("t2_rst_cycles", rst_cnt, 4);
    chk("t2_steps", step_cnt, 0);
    chk("t2_valid", smp_valid, 0);
    // Backpressure: FIFO fills, sequencer stalls in PUSH
    clr();
    smp_ready = 1'b0;
    start_run(16'd10, 32'h0);
    for (int i = 0; i < 10; i++) exp_q.push_back(word(i));
    wait_step(16'd8);
    repeat (20) @(negedge clk);
    chk("t3_stall_steps", step_cnt, 9);
    chk("t3_stall_done", steps_done, 8);
    chk("t3_stall_busy", busy, 1);
    @(posedge clk); #1;
    smp_ready = 1'b1;
    wait_idle(300);
    repeat (3) @(negedge clk);
    chk("t3_steps_done", steps_done, 10);
    chk("t3_steps", step_cnt, 10);
    chk("t3_run_done", done_cnt, 1);
    chk("t3_sb_empty", exp_q.size(), 0);
    // Abort in WAIT of step 2
    clr();
    smp_ready = 1'b0;
    start_run(16'd3, 32'h0);
    wait_step(16'd1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("t4_busy", busy, 0);
    chk("t4_steps_done", steps_done, 1);
    chk("t4_valid", smp_valid, 1);
    repeat (5) @(negedge clk);
    chk("t4_no_run_done", done_cnt, 0);
    exp_q.push_back(word(0));
    @(posedge clk); #1;
    smp_ready = 1'b1;
    start_run(16'd1, 32'h0);
    exp_q.push_back(word(0));
    wait_idle(100);
    repeat (2) @(negedge clk);
    chk("t4_restart_done", done_cnt, 1);
    chk("t4_restart_steps", steps_done, 1);
    chk("t4_sb_empty", exp_q.size(), 0);
    // start while busy, including in the FIN cycle
    clr();
    start_run(16'd2, 32'h0);
    for (int i = 0; i < 2; i++) exp_q.push_back(word(i));
    for (int c = 1; c <= 14; c++) begin
      if (c == 13) chk("t5_fin_cycle", run_done, 1);
      start = (c == 2 || c == 13);
      num_steps = 16'd5;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_steps", step_cnt, 2);
    chk("t5_run_done", done_cnt, 1);
    chk("t5_steps_done", steps_done, 2);
    // Asynchronous reset in the middle of a step
    smp_ready = 1'b0;
    start_run(16'd5, 32'hDEAD_BEEF);
    wait_step(16'd2);
    #2 rst = 1'b1;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_step", chaos_step_o, 0);
    chk("t6_core_rst", chaos_reset_o, 0);
    chk("t6_valid", smp_valid, 0);
    chk("t6_data", smp_data, 0);
    chk("t6_steps_done", steps_done, 0);
    chk("t6_shift", chaos_shift_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    smp_ready = 1'b1;
`ifdef CHAOS_TIMEOUT_EN
    clr();
    core_en = 1'b0;
    first = 0;
    start_run(16'd1, 32'h0);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (timeout_err && first == 0) first = k;
    end
    chk("t7_tmo_cycle", first, 22);
    chk("t7_busy", busy, 0);
    chk("t7_valid", smp_valid, 0);
    chk("t7_steps_done", steps_done, 0);
    chk("t7_no_run_done", done_cnt, 0);
    core_en = 1'b1;
    start_run(16'd1, 32'h0);
    exp_q.push_back(word(0));
    chk("t7_tmo_clear", timeout_err, 0);
    wait_idle(100);
`else
    chk("t7_tmo_tied", timeout_err, 0);
`endif
    repeat (3) @(negedge clk);
    chk("final_sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/chaos_step_sequencer.md
Name: chaos_step_sequencer

Overview:
Sequences the chaos generator core through a host-requested run. Per run: one reset, then N single-step/done handshakes. After each step it captures the 8-bit x/y/z/w state into a small sample FIFO. Sits between the Nios-side PIO control registers and the chaos core, replacing software-driven toggling of reset/step/done.

Parameters:
RST_CYCLES, 4, cycles chaos_reset_o is held high at run start (>=1)
FIFO_DEPTH, 8, sample FIFO entries (power of 2, >=2)
TIMEOUT_CYC, 1024, max cycles waiting for chaos_done_i (used only with CHAOS_TIMEOUT_EN)

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle run request; ignored while busy=1
num_steps  in  16  steps in the run; latched at start; 0 = reset-only run
shift_cfg  in  32  shift value for the core; latched at start
abort  in  1  terminate the run
chaos_reset_o  out  1  reset to chaos core
chaos_shift_o  out  32  latched shift_cfg
chaos_step_o  out  1  one-cycle step pulse
chaos_done_i  in  1  core step-complete (level)
chaos_x_i, chaos_y_i, chaos_z_i, chaos_w_i  in  8 each  core state
smp_data  out  32  FIFO head, packed {w,z,y,x}
smp_valid  out  1  FIFO non-empty
smp_ready  in  1  pop when smp_valid & smp_ready
busy  out  1  state != IDLE
run_done  out  1  one-cycle pulse on normal completion
steps_done  out  16  samples pushed in the current or last run
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset values: chaos_reset_o=0, chaos_shift_o=0, chaos_step_o=0, smp_valid=0, smp_data=0, busy=0, run_done=0, steps_done=0, timeout_err=0. FIFO is flushed.
- States: IDLE, RST, STEP, WAIT, PUSH, FIN.
- IDLE: on start, latch num_steps and shift_cfg, clear steps_done, go to RST. chaos_shift_o updates in the same edge.
- RST: chaos_reset_o=1 for exactly RST_CYCLES cycles. Then go to FIN if num_steps==0, else STEP.
- STEP: chaos_step_o=1 for one cycle, then WAIT.
- WAIT: chaos_done_i is sampled starting the cycle after the step pulse. On done=1, register {w,z,y,x} and go to PUSH.
- PUSH: if FIFO not full, push, increment steps_done, then go to FIN if steps_done+1==num_steps, else STEP. If FIFO is full, stay in PUSH (backpressure). No sample is ever dropped.
- FIN: run_done=1 for one cycle, then IDLE.
- Minimum per-step latency is 3 cycles (STEP, WAIT with done already high, PUSH). The next step pulse occurs no earlier than 3 cycles after the previous one.
- FIFO: push and pop in the same cycle are both honoured. When full, a pop in the same cycle as a push does not free the slot for that push; the push occurs next cycle. Output is first-word fall-through, with smp_data valid while smp_valid=1.
- abort, in any non-IDLE state: next state IDLE, chaos_step_o=0, chaos_reset_o=0, no run_done. FIFO contents and steps_done are retained. abort in IDLE is a no-op. abort has priority over start and done in the same cycle.
- start while busy: ignored, including start in the FIN cycle.
- Async reset mid-run: immediate return to reset values. The core's chaos_reset_o drops to 0.
- steps_done is 16-bit and never wraps, since it is bounded by num_steps.

Optional Feature:
CHAOS_TIMEOUT_EN:
- Defined: a counter runs in WAIT. If TIMEOUT_CYC cycles elapse without done, set timeout_err=1 (sticky until the next start or reset), skip the push, and go to IDLE without run_done.
- Undefined: WAIT waits indefinitely; timeout_err is tied to 0.

Decomposition:
- Package chaos_seq_pkg: state enum, sample packing offsets (X=0, Y=8, Z=16, W=24), DATA_W=32, STEP_W=16.
- One sub-module, chaos_sample_fifo: sync FWFT FIFO with parameter DEPTH, ports push/pop/full/empty/din/dout, async active-high reset.

Test Plan:
- start with num_steps=3 and shift_cfg=0xA5A5_0001; core model raises done 2 cycles after each step, with x/y/z/w=i, i+1, i+2, i+3. Expect: reset high for 4 cycles, 3 step pulses, FIFO words 0x03020100, 0x04030201, 0x05040302, run_done once, steps_done=3.
- num_steps=0: expect 4 reset cycles, no step pulse, run_done 5 cycles after start, FIFO empty.
- FIFO_DEPTH=8, num_steps=10, smp_ready=0: expect 8 pushes, then stall in PUSH with no further step pulse. Raising smp_ready drains the FIFO in order; all 10 samples arrive.
- abort asserted in WAIT during step 2: expect IDLE next cycle, busy=0, no run_done, 1 sample retained. A subsequent start succeeds.
- start pulsed while busy: ignored. Async reset mid-step: all outputs return to 0 immediately and the FIFO is empty.
- With CHAOS_TIMEOUT_EN and TIMEOUT_CYC=16, done is never asserted: expect timeout_err=1 after 16 WAIT cycles, IDLE, no push. The flag clears on the next start.
